ucsbece154a_memarb: RTL
=======================

# ucsbece154a_memarb

Two-requester arbiter for the single unified instruction/data memory of the multicycle core. It shares that memory between the core's memory port and a DMA/program-loader port. The memory has a fixed read latency. The core is stalled while its access is outstanding. The DMA port uses a grant/done handshake. The core has priority, and a bounded-burst counter guarantees DMA progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 1, memory read latency in cycles (legal 1..7)
- MAX_CORE_BURST, 4, consecutive contested core grants before DMA is forced (legal 1..15)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- core_req_i  in  1  core access request, level, held until stall drops
- core_we_i  in  1  core write enable
- core_adr_i  in  ADDR_W  core address
- core_wd_i  in  DATA_W  core write data
- core_rd_o  out  DATA_W  core read data, registered
- core_stall_o  out  1  core must hold its FSM/FFs
- dma_req_i  in  1  DMA request, level, held until dma_gnt_o
- dma_we_i  in  1  DMA write enable
- dma_adr_i  in  ADDR_W  DMA address
- dma_wd_i  in  DATA_W  DMA write data
- dma_gnt_o  out  1  one-cycle pulse: command accepted
- dma_done_o  out  1  one-cycle pulse: access complete
- dma_rd_o  out  DATA_W  DMA read data, valid with dma_done_o on reads
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_adr_o  out  ADDR_W  memory address
- mem_wd_o  out  DATA_W  memory write data
- mem_rd_i  in  DATA_W  memory read data, valid exactly LATENCY cycles after the mem_en_o cycle

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Owner register: 0 = core, 1 = DMA.
- IDLE: arbitrate sampled requests.
  - Only core requests: core wins.
  - Only DMA requests: DMA wins.
  - Both request: core wins unless streak == MAX_CORE_BURST, in which case DMA wins.
  - On a win, capture owner, we, adr and wd, then go to ISSUE. With no request, stay in IDLE.
- ISSUE, exactly one cycle:
  - mem_en_o = 1; mem_we_o, mem_adr_o and mem_wd_o come from the captured registers.
  - dma_gnt_o = 1 if owner = DMA.
  - Load wait counter with LATENCY, then go to WAIT.
- WAIT: decrement the counter each cycle. On the last WAIT cycle (ISSUE + LATENCY), capture mem_rd_i into core_rd_o or dma_rd_o (reads only), then go to RESP.
- RESP, one cycle:
  - Owner = core: internal core_done = 1.
  - Owner = DMA: dma_done_o = 1.
  - Next state is always IDLE.
- core_stall_o = core_req_i & ~core_done (combinational). It is low in RESP for a core access.
- Streak counter, 4 bits:
  - Increments on a core grant while dma_req_i = 1, saturating at MAX_CORE_BURST.
  - Clears on a DMA grant.
  - Clears in IDLE when dma_req_i = 0.
- Writes follow identical timing. Read-data registers are untouched on writes.
- Outside ISSUE: mem_en_o = 0 and mem_we_o = 0. mem_adr_o and mem_wd_o hold their last values.

## Timing
- Request seen in IDLE at cycle 0:
  - ISSUE in cycle 1.
  - WAIT in cycles 2..1+LATENCY.
  - RESP in cycle 2+LATENCY.
  - Next arbitration in cycle 3+LATENCY.
- Core stall spans cycles 0..1+LATENCY, i.e. LATENCY+2 cycles.
- Throughput is one access per LATENCY+3 cycles.
- Requests arriving outside IDLE wait. A core request must not change while stalled. DMA inputs may change after dma_gnt_o.
- Reset is asynchronous; assertion takes effect immediately and overrides all state:
  - State = IDLE, owner = 0, counters = 0.
  - core_rd_o, dma_rd_o, mem_adr_o and mem_wd_o = 0.
  - mem_en_o, mem_we_o, dma_gnt_o and dma_done_o = 0.
  - core_stall_o = core_req_i.
- An in-flight access is abandoned with no done pulse. After reset release, pending requests are re-arbitrated from IDLE.

## Test plan
- Reset: drive reset = 0 mid-cycle during WAIT. Required: mem_en_o, dma_done_o and core_rd_o go to 0 immediately. After release, the held core_req_i is reissued at ISSUE one cycle after the first IDLE cycle.
- Core read, LATENCY = 1: core_req_i = 1, adr 0x100 at cycle 0; memory returns 0xDEADBEEF in cycle 2. Required:
  - mem_en_o = 1, mem_adr_o = 0x100, mem_we_o = 0 in cycle 1.
  - core_stall_o high in cycles 0..2.
  - In cycle 3, core_stall_o is low and core_rd_o = 0xDEADBEEF.
- Simultaneous requests, LATENCY = 1: core and DMA both request at cycle 0; core drops its request in cycle 4. Required:
  - Core ISSUE in cycle 1.
  - DMA ISSUE with dma_gnt_o = 1 in cycle 5.
  - dma_done_o = 1 in cycle 7.
- Starvation guard, MAX_CORE_BURST = 4: core_req_i and dma_req_i held high continuously. Required: grant order core, core, core, core, DMA, core…; the streak counter reads 0 after the DMA grant.
- DMA write, LATENCY = 3: adr 0x40, wd 0x12345678. Required:
  - One cycle with mem_en_o = mem_we_o = 1 carrying those values.
  - dma_done_o 4 cycles after ISSUE.
  - dma_rd_o unchanged.
- Back-to-back DMA reads, LATENCY = 2: the DMA issues a new read right after dma_gnt_o. Required: successive ISSUE cycles 5 apart, and each dma_done_o carries the matching mem_rd_i.

Source files
------------

// File: rtl/ucsbece154a_memarb_if.sv
// Bus bundle for the unified-memory arbiter: core port, DMA port and memory port.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface ucsbece154a_memarb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              core_req_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_adr_i;
  logic [DATA_W-1:0] core_wd_i;
  logic [DATA_W-1:0] core_rd_o;
  logic              core_stall_o;

  logic              dma_req_i;
  logic              dma_we_i;
  logic [ADDR_W-1:0] dma_adr_i;
  logic [DATA_W-1:0] dma_wd_i;
  logic              dma_gnt_o;
  logic              dma_done_o;
  logic [DATA_W-1:0] dma_rd_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic [DATA_W-1:0] mem_wd_o;
  logic [DATA_W-1:0] mem_rd_i;

  modport slave (
    input  core_req_i, core_we_i, core_adr_i, core_wd_i,
    input  dma_req_i, dma_we_i, dma_adr_i, dma_wd_i,
    input  mem_rd_i,
    output core_rd_o, core_stall_o,
    output dma_gnt_o, dma_done_o, dma_rd_o,
    output mem_en_o, mem_we_o, mem_adr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_adr_i, core_wd_i,
    output dma_req_i, dma_we_i, dma_adr_i, dma_wd_i,
    output mem_rd_i,
    input  core_rd_o, core_stall_o,
    input  dma_gnt_o, dma_done_o, dma_rd_o,
    input  mem_en_o, mem_we_o, mem_adr_o, mem_wd_o
  );
endinterface

// File: rtl/ucsbece154a_memarb.sv
// Core/DMA arbiter for a single fixed-latency memory. Core has priority; a bounded
// streak of contested core grants forces a DMA grant so the loader always progresses.
module ucsbece154a_memarb #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned MAX_CORE_BURST = 4
) (
  input logic                  clk,
  input logic                  reset,
  ucsbece154a_memarb_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;  // 0 = core, 1 = DMA
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [2:0]        wait_q, wait_d;
  logic [3:0]        streak_q, streak_d;
  logic [DATA_W-1:0] core_rd_q, core_rd_d;
  logic [DATA_W-1:0] dma_rd_q, dma_rd_d;
  logic              core_win, dma_win, force_dma, core_done;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wd_d      = wd_q;
    wait_d    = wait_q;
    streak_d  = streak_q;
    core_rd_d = core_rd_q;
    dma_rd_d  = dma_rd_q;
    force_dma = (streak_q == 4'(MAX_CORE_BURST));
    core_win  = 1'b0;
    dma_win   = 1'b0;
    unique case (state_q)
      StIdle: begin
        core_win = bus.core_req_i & ~(bus.dma_req_i & force_dma);
        dma_win  = bus.dma_req_i & ~core_win;
        // A contested core win implies streak < MAX, so the increment saturates at MAX.
        if (!bus.dma_req_i || dma_win) begin
          streak_d = 4'd0;
        end else if (core_win) begin
          streak_d = streak_q + 4'd1;
        end
        if (core_win || dma_win) begin
          owner_d = dma_win;
          we_d    = dma_win ? bus.dma_we_i  : bus.core_we_i;
          adr_d   = dma_win ? bus.dma_adr_i : bus.core_adr_i;
          wd_d    = dma_win ? bus.dma_wd_i  : bus.core_wd_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_d  = 3'(LATENCY);
        state_d = StWait;
      end
      StWait: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          if (!we_q) begin
            if (owner_q) dma_rd_d = bus.mem_rd_i;
            else         core_rd_d = bus.mem_rd_i;
          end
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wd_q      <= '0;
      wait_q    <= 3'd0;
      streak_q  <= 4'd0;
      core_rd_q <= '0;
      dma_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wd_q      <= wd_d;
      wait_q    <= wait_d;
      streak_q  <= streak_d;
      core_rd_q <= core_rd_d;
      dma_rd_q  <= dma_rd_d;
    end
  end

  // Captured command registers double as the held memory address/data outputs.
  assign core_done        = (state_q == StResp) & ~owner_q;
  assign bus.core_stall_o = bus.core_req_i & ~core_done;
  assign bus.core_rd_o    = core_rd_q;
  assign bus.dma_rd_o     = dma_rd_q;
  assign bus.dma_gnt_o    = (state_q == StIssue) & owner_q;
  assign bus.dma_done_o   = (state_q == StResp) & owner_q;
  assign bus.mem_en_o     = (state_q == StIssue);
  assign bus.mem_we_o     = (state_q == StIssue) & we_q;
  assign bus.mem_adr_o    = adr_q;
  assign bus.mem_wd_o     = wd_q;

endmodule
